// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Optional feature macro used by this block: KEY_DEBOUNCER_AUTO_REPEAT_EN.
package key_debouncer_pkg;

  // Per-channel debounce state; the encoding is fixed at 2 bits.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Converts a duration in ms to clock cycles. Anything under 2 cycles is
  // raised to 2 so the wait states always last at least one counting cycle.
  function automatic int ms_to_cycles(input int clock_freq, input int ms);
    int cycles;
    cycles = (clock_freq / 1000) * ms;
    return (cycles < 2) ? 2 : cycles;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// Debounce FSM for one key: clean level plus press/release strobes, and an
// optional auto-repeat strobe enabled by KEY_DEBOUNCER_AUTO_REPEAT_EN.
// raw is already polarity-normalised (1 = pressed) and synchronised.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_t       state;
  logic [CNT_W-1:0] count;

  // Debounce FSM: a level change is accepted only after raw has held the new
  // value for DEBOUNCE_CYCLES consecutive edges; the counter leaves its state
  // at CNT_LAST, so it never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (raw) begin
            state <= PRESS_WAIT;
            count <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!raw) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state <= HELD;
            count <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        HELD: begin
          if (!raw) begin
            state <= RELEASE_WAIT;
            count <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (raw) begin
            state <= HELD;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state       <= IDLE;
            count       <= '0;
            level       <= 1'b0;
            release_stb <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first_done;
  logic             entering_held;
  logic             releasing;
  logic [RPT_W-1:0] rpt_last;

  assign entering_held = (state == PRESS_WAIT) && raw && (count == CNT_LAST);
  assign releasing     = (state == RELEASE_WAIT) && !raw && (count == CNT_LAST);
  assign rpt_last      = rpt_first_done ? RATE_LAST : DELAY_LAST;

  // Repeat timer: runs through HELD and RELEASE_WAIT (glitches do not restart
  // it), restarts on the press, and a strobe landing on the release edge is
  // dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
      repeat_stb     <= 1'b0;
    end else begin
      repeat_stb <= 1'b0;
      if (entering_held || releasing || (state == IDLE) || (state == PRESS_WAIT)) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b0;
      end else if (rpt_cnt == rpt_last) begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b1;
        repeat_stb     <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  assign repeat_stb = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Debounce and edge-event generator for the DE1-SoC push-buttons.
// Normalises key polarity and runs one independent channel per key.
// Define KEY_DEBOUNCER_AUTO_REPEAT_EN to enable the keyRepeat strobes;
// otherwise keyRepeat is constant 0.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int CLOCK_FREQ      = 50000000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keyIn,
  output logic [NUM_KEYS-1:0] keyLevel,
  output logic [NUM_KEYS-1:0] keyPress,
  output logic [NUM_KEYS-1:0] keyRelease,
  output logic [NUM_KEYS-1:0] keyRepeat
);

  localparam int DEBOUNCE_CYCLES = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
  localparam int REPEAT_DELAY    = ms_to_cycles(CLOCK_FREQ, REPEAT_DELAY_MS);
  localparam int REPEAT_RATE     = ms_to_cycles(CLOCK_FREQ, REPEAT_RATE_MS);
`endif

  // Reject nonsensical timing parameters at elaboration.
  if (DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_params
    $error("key_debouncer: timing parameters must be at least 1 ms");
  end

  logic [NUM_KEYS-1:0] raw;

  assign raw = (ACTIVE_LOW != 0) ? ~keyIn : keyIn;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
`endif
    ) u_chan (
      .clock       (clock),
      .reset_n     (reset_n),
      .raw         (raw[k]),
      .level       (keyLevel[k]),
      .press       (keyPress[k]),
      .release_stb (keyRelease[k]),
      .repeat_stb  (keyRepeat[k])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios followed by
// randomized key activity, all compared each cycle against a run-length
// reference model. Honours KEY_DEBOUNCER_AUTO_REPEAT_EN.
module tb_key_debouncer;

  localparam int CF  = 1000;
  localparam int DMS = 10;
  localparam int RMS = 50;
  localparam int PMS = 20;
  localparam int DC  = CF / 1000 * DMS;
  localparam int RD  = CF / 1000 * RMS;
  localparam int RR  = CF / 1000 * PMS;
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] keyIn = 4'hF;
  logic [3:0] keyLevel, keyPress, keyRelease, keyRepeat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: debounced level, run of samples disagreeing with
  // it, and cycles since the press while held.
  logic [3:0] m_level = '0, m_press = '0, m_rel = '0, m_rpt = '0;
  int run [4];
  int age [4];
  int obs_press [4];
  int obs_rel [4];
  int obs_rpt [4];
  logic [3:0] rk;
  int hold [4];
  int base_press, base_rel, base_rpt;

  key_debouncer #(
    .NUM_KEYS        (4),
    .CLOCK_FREQ      (CF),
    .DEBOUNCE_MS     (DMS),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY_MS (RMS),
    .REPEAT_RATE_MS  (PMS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .keyIn      (keyIn),
    .keyLevel   (keyLevel),
    .keyPress   (keyPress),
    .keyRelease (keyRelease),
    .keyRepeat  (keyRepeat)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A level flips once DC+1 consecutive samples disagree with it; repeats
  // fall at RD, RD+RR, ... cycles after the press while still held.
  task automatic model_update(input logic [3:0] raw, input logic rst_n);
    m_press = '0;
    m_rel   = '0;
    m_rpt   = '0;
    if (!rst_n) begin
      m_level = '0;
      for (int k = 0; k < 4; k++) begin
        run[k] = 0;
        age[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (raw[k] != m_level[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DC + 1) begin
          run[k]     = 0;
          m_level[k] = raw[k];
          if (raw[k]) begin
            m_press[k] = 1'b1;
            age[k]     = 0;
          end else begin
            m_rel[k] = 1'b1;
          end
        end else if (m_level[k]) begin
          age[k]++;
          if (REPEAT_ON && age[k] >= RD && ((age[k] - RD) % RR) == 0) m_rpt[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] keys, input logic rst_n);
    keyIn   = keys;
    reset_n = rst_n;
    @(posedge clock);
    model_update(~keys, rst_n);
    #1;
    check_val("keyLevel", 32'(keyLevel), 32'(m_level));
    check_val("keyPress", 32'(keyPress), 32'(m_press));
    check_val("keyRelease", 32'(keyRelease), 32'(m_rel));
    check_val("keyRepeat", 32'(keyRepeat), 32'(m_rpt));
    for (int k = 0; k < 4; k++) begin
      obs_press[k] += int'(keyPress[k]);
      obs_rel[k]   += int'(keyRelease[k]);
      obs_rpt[k]   += int'(keyRepeat[k]);
    end
  endtask

  task automatic steps(input int n, input logic [3:0] keys, input logic rst_n);
    for (int i = 0; i < n; i++) step(keys, rst_n);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      run[k] = 0; age[k] = 0; obs_press[k] = 0; obs_rel[k] = 0; obs_rpt[k] = 0; hold[k] = 0;
    end

    // Reset state
    steps(3, 4'hF, 1'b0);
    check_val("reset_outputs", 32'({keyLevel, keyPress, keyRelease, keyRepeat}), 32'h0);
    steps(5, 4'hF, 1'b1);

    // 1. Clean press on key0: level rises exactly DC edges after the first sample
    steps(DC, 4'b1110, 1'b1);
    check_val("clean_press_early", 32'(keyLevel), 32'h0);
    step(4'b1110, 1'b1);
    check_val("clean_press_pulse", 32'(keyPress), 32'h1);
    check_val("clean_press_level", 32'(keyLevel), 32'h1);
    steps(5, 4'b1110, 1'b1);
    check_val("clean_press_single", 32'(obs_press[0]), 32'd1);

    // 2. Bounce on key1 (key0 kept held): no change, then a single press
    steps(4, 4'b1100, 1'b1);
    steps(2, 4'b1110, 1'b1);
    steps(7, 4'b1100, 1'b1);
    steps(5, 4'b1110, 1'b1);
    check_val("bounce_no_press", 32'(obs_press[1]), 32'd0);
    check_val("bounce_no_level", 32'(keyLevel[1]), 32'd0);
    steps(12, 4'b1100, 1'b1);
    check_val("bounce_then_press", 32'(obs_press[1]), 32'd1);
    steps(15, 4'b1110, 1'b1);

    // 3. Release of key0 with a one-cycle re-press glitch
    base_rel = obs_rel[0];
    steps(5, 4'b1111, 1'b1);
    step(4'b1110, 1'b1);
    check_val("glitch_level_held", 32'(keyLevel[0]), 32'd1);
    steps(DC, 4'b1111, 1'b1);
    check_val("glitch_release_early", 32'(keyLevel[0]), 32'd1);
    step(4'b1111, 1'b1);
    check_val("glitch_release_pulse", 32'(keyRelease), 32'h1);
    steps(5, 4'b1111, 1'b1);
    check_val("glitch_release_once", 32'(obs_rel[0] - base_rel), 32'd1);

    // 4. Reset while key2 is mid-debounce at count 6
    steps(7, 4'b1011, 1'b1);
    step(4'b1011, 1'b0);
    check_val("midreset_outputs", 32'({keyLevel, keyPress, keyRelease, keyRepeat}), 32'h0);
    steps(DC, 4'b1011, 1'b1);
    check_val("midreset_no_early_press", 32'(keyLevel[2]), 32'd0);
    step(4'b1011, 1'b1);
    check_val("midreset_press", 32'(keyPress), 32'b0100);
    steps(DC + 5, 4'b1111, 1'b1);

    // 5. All keys together, then key2 released alone
    steps(DC + 1, 4'b0000, 1'b1);
    check_val("simul_press", 32'(keyPress), 32'hF);
    steps(5, 4'b0000, 1'b1);
    steps(DC + 1, 4'b0100, 1'b1);
    check_val("single_release", 32'(keyRelease), 32'b0100);
    steps(DC + 5, 4'b1111, 1'b1);

    // 6. Auto-repeat on key3: release lands exactly on the would-be 5th repeat
    base_rpt   = obs_rpt[3];
    base_press = obs_press[3];
    steps(DC + 1, 4'b0111, 1'b1);
    check_val("repeat_press", 32'(obs_press[3] - base_press), 32'd1);
    steps(RD + 3 * RR + 9, 4'b0111, 1'b1);
    steps(DC + 20, 4'b1111, 1'b1);
    check_val("repeat_count", 32'(obs_rpt[3] - base_rpt), REPEAT_ON ? 32'd4 : 32'd0);

    // 7. Randomized activity with occasional long holds and rare resets
    rk = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          rk[k]   = ~rk[k];
          hold[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 160))
                                                : int'($urandom_range(1, 25));
        end else begin
          hold[k]--;
        end
      end
      step(rk, ($urandom_range(0, 699) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
